// File: rtl/run_counter4.sv
// 4-bit modulo-MOD run counter with IDLE/RUN/DONE sequencing, synchronous load,
// terminal-count, wrap pulse and sticky overflow flags.

module incrementer4bit (
   input  logic [3:0] i_a,
   output logic [4:0] o_sum
);
   assign o_sum = {1'b0, i_a} + 5'd1;
endmodule

module run_counter4 #(
   parameter int MOD     = 16,
   parameter int ONESHOT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       clr_ovf,
   output logic [3:0] count,
   output logic       busy,
   output logic       done,
   output logic       tc,
   output logic       wrap,
   output logic       ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [4:0] MOD_W = 5'(MOD);
   localparam logic [3:0] LAST  = 4'(MOD - 1);

   state_t     r_state;
   logic [3:0] r_count;
   logic       r_wrap;
   logic       r_ovf;

   logic [4:0] w_sum;
   logic [3:0] w_load_val;
   logic       w_inc;
   logic       w_wrap_evt;

   incrementer4bit u_inc (
      .i_a   (r_count),
      .o_sum (w_sum)
   );

   assign w_load_val = (load_val > LAST) ? LAST : load_val;
   assign w_inc      = (r_state == ST_RUN) && en && !load;
   // A 5-bit compare covers MOD=16, where the wrap shows up as the carry bit.
   assign w_wrap_evt = w_inc && (w_sum == MOD_W);

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= 4'd0;
         r_wrap  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wrap <= w_wrap_evt;

         if (w_wrap_evt)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;

         if (load)
            r_count <= w_load_val;
         else if (w_wrap_evt)
            r_count <= 4'd0;
         else if (w_inc)
            r_count <= w_sum[3:0];

         case (r_state)
            ST_IDLE: if (start) r_state <= ST_RUN;
            ST_DONE: if (start) r_state <= ST_RUN;
            ST_RUN: begin
               // stop outranks the one-shot transition on the same edge.
               if (stop)
                  r_state <= ST_IDLE;
               else if (w_wrap_evt && (ONESHOT != 0))
                  r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign count = r_count;
   assign busy  = (r_state == ST_RUN);
   assign done  = (r_state == ST_DONE);
   assign tc    = w_wrap_evt;
   assign wrap  = r_wrap;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_run_counter4.sv
// Directed bench for run_counter4: one free-running MOD=16 instance and one
// one-shot MOD=10 instance sharing the same stimulus.

module tb_run_counter4;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, en, load, clr_ovf;
   logic [3:0] load_val;

   logic [3:0] count16, count10;
   logic       busy16, done16, tc16, wrap16, ovf16;
   logic       busy10, done10, tc10, wrap10, ovf10;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   run_counter4 #(.MOD(16), .ONESHOT(0)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
      .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count16), .busy(busy16), .done(done16), .tc(tc16),
      .wrap(wrap16), .ovf(ovf16)
   );

   run_counter4 #(.MOD(10), .ONESHOT(1)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
      .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count10), .busy(busy10), .done(done10), .tc(tc10),
      .wrap(wrap10), .ovf(ovf10)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 0; stop = 0; en = 0; load = 0; load_val = 0; clr_ovf = 0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_count", count16, 4'd0);
      chk("rst_busy", {3'b0, busy16}, 4'd0);
      chk("rst_done", {3'b0, done16}, 4'd0);
      start = 1; tick(); start = 0;
      en = 1;
      repeat (9) tick();
      chk("pre_rst_count", count16, 4'd9);
      chk("pre_rst_busy", {3'b0, busy16}, 4'd1);
      chk("pre_rst_tc", {3'b0, tc16}, 4'd0);
      rst_n = 1'b0;
      #2;
      chk("async_rst_count", count16, 4'd0);
      chk("async_rst_busy", {3'b0, busy16}, 4'd0);
      chk("async_rst_ovf", {3'b0, ovf16}, 4'd0);
      chk("async_rst_wrap", {3'b0, wrap16}, 4'd0);
      chk("async_rst_tc", {3'b0, tc16}, 4'd0);
      en = 0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_free_run();
      do_reset();
      start = 1; tick(); start = 0;
      en = 1;
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("fr_count_%0d", i), count16, 4'(i % 16));
         chk($sformatf("fr_tc_%0d", i), {3'b0, tc16}, {3'b0, (i == 15)});
         tick();
         chk($sformatf("fr_wrap_%0d", i), {3'b0, wrap16}, {3'b0, (i == 15)});
      end
      chk("fr_count_end", count16, 4'd1);
      chk("fr_ovf", {3'b0, ovf16}, 4'd1);
      chk("fr_busy", {3'b0, busy16}, 4'd1);
      en = 0;
   endtask

   task automatic test_oneshot();
      do_reset();
      start = 1; tick(); start = 0;
      en = 1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("os_count_%0d", i), count10, 4'(i));
         chk($sformatf("os_tc_%0d", i), {3'b0, tc10}, {3'b0, (i == 9)});
         tick();
      end
      chk("os_count_wrapped", count10, 4'd0);
      chk("os_done", {3'b0, done10}, 4'd1);
      chk("os_busy", {3'b0, busy10}, 4'd0);
      chk("os_wrap", {3'b0, wrap10}, 4'd1);
      chk("os_ovf", {3'b0, ovf10}, 4'd1);
      repeat (3) tick();
      chk("os_hold_count", count10, 4'd0);
      chk("os_hold_wrap", {3'b0, wrap10}, 4'd0);
      chk("os_hold_done", {3'b0, done10}, 4'd1);
      chk("os_hold_tc", {3'b0, tc10}, 4'd0);
      start = 1; tick(); start = 0;
      chk("os_restart_busy", {3'b0, busy10}, 4'd1);
      chk("os_restart_count", count10, 4'd0);
      tick();
      chk("os_restart_inc", count10, 4'd1);
      en = 0;
   endtask

   task automatic test_load();
      do_reset();
      load = 1; load_val = 4'd12; tick(); load = 0;
      chk("ld_clamp10", count10, 4'd9);
      chk("ld_noclamp16", count16, 4'd12);
      chk("ld_idle", {3'b0, busy10}, 4'd0);
      start = 1; tick(); start = 0;
      chk("ld_run", {3'b0, busy10}, 4'd1);
      en = 1; load = 1; load_val = 4'd3;
      #1;
      chk("ld_tc_suppressed", {3'b0, tc10}, 4'd0);
      tick();
      chk("ld_over_en", count10, 4'd3);
      chk("ld_no_wrap", {3'b0, wrap10}, 4'd0);
      chk("ld_no_ovf", {3'b0, ovf10}, 4'd0);
      chk("ld_state_kept", {3'b0, busy10}, 4'd1);
      load = 0; en = 0;
   endtask

   task automatic test_stop_start();
      do_reset();
      start = 1; tick(); start = 0;
      en = 1;
      repeat (5) tick();
      en = 0;
      chk("ss_count5", count16, 4'd5);
      stop = 1; tick(); stop = 0;
      chk("ss_idle", {3'b0, busy16}, 4'd0);
      chk("ss_hold_stop", count16, 4'd5);
      en = 1;
      repeat (2) tick();
      chk("ss_hold_idle_en", count16, 4'd5);
      chk("ss_tc_idle", {3'b0, tc16}, 4'd0);
      en = 0;
      start = 1; tick(); start = 0;
      chk("ss_rerun", {3'b0, busy16}, 4'd1);
      en = 1; tick(); en = 0;
      chk("ss_count6", count16, 4'd6);
   endtask

   task automatic test_ovf_priority();
      do_reset();
      start = 1; tick(); start = 0;
      load = 1; load_val = 4'd14; tick(); load = 0;
      chk("ovf_load14", count16, 4'd14);
      en = 1; tick();
      chk("ovf_count15", count16, 4'd15);
      clr_ovf = 1;
      chk("ovf_tc", {3'b0, tc16}, 4'd1);
      tick();
      chk("ovf_set_wins", {3'b0, ovf16}, 4'd1);
      chk("ovf_wrap", {3'b0, wrap16}, 4'd1);
      chk("ovf_wrap_count", count16, 4'd0);
      en = 0;
      tick();
      clr_ovf = 0;
      chk("ovf_cleared", {3'b0, ovf16}, 4'd0);
      chk("ovf_wrap_gone", {3'b0, wrap16}, 4'd0);
   endtask

   task automatic test_stop_wrap();
      do_reset();
      start = 1; tick(); start = 0;
      load = 1; load_val = 4'd9; tick(); load = 0;
      en = 1; stop = 1; tick(); en = 0; stop = 0;
      chk("sw_idle_not_done", {3'b0, done10}, 4'd0);
      chk("sw_not_busy", {3'b0, busy10}, 4'd0);
      chk("sw_wrap", {3'b0, wrap10}, 4'd1);
      chk("sw_count", count10, 4'd0);
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_oneshot();
      test_load();
      test_stop_start();
      test_ovf_priority();
      test_stop_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
